fsm_seq_transmitter: RTL

Moore-style serial pattern transmitter: captures a parallel bit pattern on a start request and emits it one bit per clock, MSB of the selected field first, with optional continuous looping. It is the driving end of the serial `in` stream consumed by the team's Moore sequence detectors. It replaces hand-written testbench stimulus with a synthesizable source, and exposes a debug state number in the same way those detectors do.

---
 rtl/fsm_seq_transmitter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fsm_seq_transmitter.sv
// Moore serial pattern transmitter: captures a parallel pattern on start
// and shifts it out MSB-first of the selected field, optionally looping.
module fsm_seq_transmitter #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             loop,
  input  logic             stop,
  output logic             y,
  output logic             y_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_num
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [LEN_W-1:0] LMAX = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] bit_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // Out-of-range lengths fall back to the full register width.
  always_comb begin
    len_eff = len;
    if (len == '0 || len > LMAX)
      len_eff = LMAX;
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start)
          state_d = LOAD;
      end
      LOAD: begin
        shreg_d = pattern;
        len_d   = len_eff;
        cnt_d   = len_eff;
        state_d = SHIFT;
      end
      SHIFT: begin
        cnt_d = cnt_q - ONE;
        if (stop) begin
          state_d = DONE;
        end else if (cnt_q == ONE) begin
          if (loop)
            cnt_d = len_q;
          else
            state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    y         = 1'b0;
    y_valid   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    state_num = state_q;
    bit_idx   = cnt_q - ONE;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
      end
      SHIFT: begin
        y_valid = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
          if (bit_idx == LEN_W'(i))
            y = shreg_q[i];
        end
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
